sar_adc_ctrl: RTL



---
 rtl/sar_adc_pkg.sv | 30 +++
 rtl/sar_adc_if.sv | 43 ++++
 rtl/sar_adc_ctrl_sync2.sv | 29 ++
 rtl/sar_adc_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// ---------------------------------------------------------------------------
// sar_adc_pkg
// Shared definitions for the successive-approximation ADC controller:
//   - default parameter values
//   - conversion FSM state encoding
//   - counter-width helper used to size the cycle counter and bit index
// ---------------------------------------------------------------------------
package sar_adc_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SAMPLE_CYCLES = 4;
    localparam int DEF_SETTLE_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sar_adc_if.sv
// ---------------------------------------------------------------------------
// sar_adc_if
// Bundle of the SAR ADC controller's request/comparator inputs and its
// ladder/result outputs.
//   master : host side (drives ena/start/continuous and the comparator line)
//   slave  : controller side
// Signals:
//   ena, start, continuous   control requests
//   cmp_in                   raw asynchronous comparator output (Vin >= Vdac)
//   dac_code                 trial code to the R2R ladder
//   sample_hold              1 = track, 0 = hold
//   busy                     conversion in progress
//   result, result_valid     last completed conversion and its 1-cycle strobe
//   overrun                  sticky: start seen while busy
// ---------------------------------------------------------------------------
interface sar_adc_if
    import sar_adc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             ena;
    logic             start;
    logic             continuous;
    logic             cmp_in;
    logic [WIDTH-1:0] dac_code;
    logic             sample_hold;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             overrun;

    modport master (
        output ena, start, continuous, cmp_in,
        input  dac_code, sample_hold, busy, result, result_valid, overrun
    );

    modport slave (
        input  ena, start, continuous, cmp_in,
        output dac_code, sample_hold, busy, result, result_valid, overrun
    );

endinterface

// File: rtl/sar_adc_ctrl_sync2.sv
// ---------------------------------------------------------------------------
// sar_adc_ctrl_sync2
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   d      asynchronous input
//   q      synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sar_adc_ctrl_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// ---------------------------------------------------------------------------
// sar_adc_ctrl
// Successive-approximation ADC controller. Drives trial codes onto an R2R
// ladder, reads back an external comparator through a 2-flop synchronizer
// and resolves one bit per SETTLE/DECIDE pair, MSB first.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    sar_adc_if.slave (ena, start, continuous, cmp_in in;
//          dac_code, sample_hold, busy, result, result_valid, overrun out)
//
// Timing with defaults: result_valid rises 37 cycles after the edge that
// accepts start (SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1), and a
// continuous run repeats with the same period.
// ---------------------------------------------------------------------------
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic     clk,
    input  logic     rst_n,
    sar_adc_if.slave bus
);

    // SETTLE must cover the two synchronizer flops plus one cycle of
    // analog settling, otherwise DECIDE would see a stale comparator value.
    if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
        $error("sar_adc_ctrl: WIDTH must be in 2..8");
    end
    if (SAMPLE_CYCLES < 1) begin : g_bad_sample
        $error("sar_adc_ctrl: SAMPLE_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("sar_adc_ctrl: SETTLE_CYCLES must be >= 3");
    end

    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX - 1);
    localparam int IDX_W   = cnt_width(WIDTH - 1);

    // Counters are loaded with N-1 and the state exits when they reach 0,
    // giving exactly N cycles in the state.
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nx;
    logic [WIDTH-1:0] code_q, code_nx;
    logic [WIDTH-1:0] result_q, result_nx;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             valid_q, valid_nx;
    logic             ovr_q, ovr_nx;

    logic             cmp_s;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] decided;

    sar_adc_ctrl_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.cmp_in),
        .q     (cmp_s)
    );

    // The bit under trial is kept when Vin >= Vdac, cleared otherwise.
    // Only set/clear of individual bits is used, so no carries can occur.
    assign bit_mask = WIDTH'(1) << idx_q;
    assign decided  = cmp_s ? code_q : (code_q & ~bit_mask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        code_nx   = code_q;
        result_nx = result_q;
        idx_nx    = idx_q;
        cnt_nx    = cnt_q;
        valid_nx  = 1'b0;
        ovr_nx    = ovr_q;

        if (!bus.ena) begin
            // Abort: back to IDLE with the ladder parked at 0; result and
            // overrun keep their values and no completion is reported.
            state_nx = ST_IDLE;
            code_nx  = '0;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            if (bus.start && (state != ST_IDLE)) begin
                ovr_nx = 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    code_nx = '0;
                    if (bus.start) begin
                        state_nx = ST_SAMPLE;
                        ovr_nx   = 1'b0;
                        cnt_nx   = SAMPLE_LOAD;
                    end
                end

                ST_SAMPLE: begin
                    if (cnt_q == '0) begin
                        state_nx = ST_SETTLE;
                        idx_nx   = IDX_MSB;
                        code_nx  = MSB_CODE;
                        cnt_nx   = SETTLE_LOAD;
                    end else begin
                        cnt_nx = cnt_q - CNT_W'(1);
                    end
                end

                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_nx = ST_DECIDE;
                    end else begin
                        cnt_nx = cnt_q - CNT_W'(1);
                    end
                end

                ST_DECIDE: begin
                    code_nx = decided;
                    if (idx_q != '0) begin
                        // Resolve this bit and raise the next-lower trial bit
                        // in the same update.
                        code_nx  = decided | (bit_mask >> 1);
                        idx_nx   = idx_q - IDX_W'(1);
                        cnt_nx   = SETTLE_LOAD;
                        state_nx = ST_SETTLE;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end

                ST_DONE: begin
                    result_nx = code_q;
                    valid_nx  = 1'b1;
                    code_nx   = '0;
                    if (bus.continuous) begin
                        state_nx = ST_SAMPLE;
                        cnt_nx   = SAMPLE_LOAD;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end

                default: begin
                    state_nx = ST_IDLE;
                    code_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            code_q   <= code_nx;
            result_q <= result_nx;
            idx_q    <= idx_nx;
            cnt_q    <= cnt_nx;
            valid_q  <= valid_nx;
            ovr_q    <= ovr_nx;
        end
    end

    assign bus.dac_code     = code_q;
    assign bus.sample_hold  = (state == ST_SAMPLE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.overrun      = ovr_q;

endmodule
